call_ret_stack: RTL and testbench
=================================

Name: call_ret_stack

Overview:
- Subroutine-linkage unit for the program-flow group.
- The existing jump units only redirect the PC forward. This block handles both ends of a subroutine: CALL pushes the return address onto a hardware stack and redirects to the target; RET pops that address and redirects back.
- Its output feeds the PC register the same way the jump units do: a new_pc value qualified by a load strobe.

Parameters:
- ADDR_W, 20, width of pc, call_address and new_pc.
- DEPTH, 8, number of return-address entries; must be a power of two, minimum 2.
- PTR_W, 3, log2(DEPTH); stack-pointer width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- pc  input  ADDR_W  address of the instruction currently executing.
- call_address  input  ADDR_W  CALL target from the GPR.
- call_req  input  1  CALL requested this cycle.
- ret_req  input  1  RET requested this cycle.
- sign_flag  input  1  condition input; used only when CALL_RET_COND_EN is defined.
- flag_clr  input  1  clears the sticky error flags.
- new_pc  output  ADDR_W  redirect target.
- pc_load  output  1  one-cycle strobe; new_pc is valid while it is high.
- depth  output  PTR_W+1  current number of stored entries, 0..DEPTH.
- full  output  1  high when depth == DEPTH.
- empty  output  1  high when depth == 0.
- overflow  output  1  sticky: a CALL was attempted while full.
- underflow  output  1  sticky: a RET was attempted while empty.

Behaviour:
- Reset (rst_n low at a rising edge): new_pc = 0, pc_load = 0, depth = 0, empty = 1, full = 0, overflow = 0, underflow = 0. Stack contents are don't-care.
- Reset takes priority over every other input, including a request in the same cycle. A reset mid-sequence discards all stored entries.
- Latency: a request sampled at edge N produces new_pc/pc_load, with depth updated, on the cycle following edge N.
- pc_load is high for exactly one cycle per accepted request and low on every other cycle.
- new_pc holds its last value when pc_load is low.
- Accepted CALL, when not full:
  - mem[sp] <= (pc + 1) mod 2^ADDR_W, so 20'hFFFFF wraps to 20'h00000.
  - sp <= sp + 1.
  - new_pc <= call_address; pc_load <= 1.
- Accepted RET, when not empty:
  - sp <= sp - 1.
  - new_pc <= mem[sp-1]; pc_load <= 1.
- CALL while full: no push, no redirect (pc_load = 0), overflow <= 1, depth unchanged.
- RET while empty: no pop, no redirect, underflow <= 1, depth unchanged.
- call_req and ret_req both high: CALL has priority and RET is ignored entirely (no flag).
- overflow and underflow remain set until flag_clr or reset.
- flag_clr in the same cycle as a new error event: the set wins.
- full and empty are combinational from depth and are consistent with depth on every cycle.
- Back-to-back requests on consecutive cycles are all accepted (throughput one per cycle). Example: CALL then RET on the next cycle returns to pc+1 of the CALL.

Optional Feature:
- Macro: CALL_RET_COND_EN.
- Defined: a request is accepted only if sign_flag == 1 in the sampling cycle (CALLS/RETS semantics).
  - If sign_flag == 0, the request is a no-op: no push/pop, pc_load = 0, and no overflow/underflow even when full/empty.
- Not defined: sign_flag is ignored and every call_req/ret_req is unconditional.

Test Plan:
- Basic linkage: reset, then pc = 20'h00100, call_address = 20'hABCDE, call_req for 1 cycle.
  - Next cycle: new_pc = 20'hABCDE, pc_load = 1, depth = 1.
  - Then ret_req for 1 cycle: new_pc = 20'h00101, pc_load = 1, depth = 0, empty = 1.
- Nesting / LIFO order: 3 CALLs from pc = 20'h00010, 20'h00020, 20'h00030, then 3 RETs.
  - new_pc sequence on the RETs: 20'h00031, 20'h00021, 20'h00011.
- Full/overflow: 8 CALLs, then a 9th CALL.
  - After the 9th: full = 1, overflow = 1, pc_load = 0, depth = 8.
  - The next RET still returns the 8th entry.
  - flag_clr clears overflow.
- Empty/underflow and wrap: RET from reset gives underflow = 1, pc_load = 0. CALL at pc = 20'hFFFFF followed by RET gives new_pc = 20'h00000.
- Simultaneous and reset: call_req and ret_req together with depth = 0 gives a push only (depth = 1, new_pc = call_address).
  - rst_n low with call_req high gives depth = 0, pc_load = 0.
- Condition (CALL_RET_COND_EN defined): call_req with sign_flag = 0 gives pc_load = 0, depth = 0. With sign_flag = 1 the call is accepted, as in the basic case.

Source files
------------

// File: rtl/call_ret_stack.sv
// Subroutine linkage: CALL pushes pc+1 and redirects to call_address, RET pops and redirects back.
// Latency: one cycle from request to new_pc/pc_load. No backpressure; CALL when full or RET when empty sets a sticky flag.
// Optional CALL_RET_COND_EN: requests are accepted only when sign_flag is set.
module call_ret_stack #(
  parameter int ADDR_W = 20,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] call_address,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic              sign_flag,
  input  logic              flag_clr,
  output logic [ADDR_W-1:0] new_pc,
  output logic              pc_load,
  output logic [PTR_W:0]    depth,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  sp;
  logic [PTR_W-1:0]  sp_top;
  logic              cond;
  logic              do_call;
  logic              do_ret;
  logic              push;
  logic              pop;

`ifdef CALL_RET_COND_EN
  assign cond = sign_flag;
`else
  logic unused_sign_flag;
  assign unused_sign_flag = sign_flag;
  assign cond = 1'b1;
`endif

  // When full, sp wraps to 0; it is never written then, and sp_top still points at the top entry.
  assign sp      = depth[PTR_W-1:0];
  assign sp_top  = sp - PTR_W'(1);
  assign full    = (depth == (PTR_W+1)'(DEPTH));
  assign empty   = (depth == '0);

  // CALL wins over a simultaneous RET; the RET is dropped without raising any flag.
  assign do_call = call_req & cond;
  assign do_ret  = ret_req & ~call_req & cond;
  assign push    = do_call & ~full;
  assign pop     = do_ret & ~empty;

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[sp] <= pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      new_pc    <= '0;
      pc_load   <= 1'b0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pc_load <= push | pop;
      if (push) begin
        depth  <= depth + (PTR_W+1)'(1);
        new_pc <= call_address;
      end else if (pop) begin
        depth  <= depth - (PTR_W+1)'(1);
        new_pc <= mem[sp_top];
      end

      // A new error event in the same cycle as flag_clr leaves the flag set.
      if (do_call && full) begin
        overflow <= 1'b1;
      end else if (flag_clr) begin
        overflow <= 1'b0;
      end

      if (do_ret && empty) begin
        underflow <= 1'b1;
      end else if (flag_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_call_ret_stack.sv
// Bench for call_ret_stack: directed linkage scenarios followed by random traffic against a queue model.
module tb_call_ret_stack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] pc;
  logic [19:0] call_address;
  logic        call_req;
  logic        ret_req;
  logic        sign_flag;
  logic        flag_clr;
  logic [19:0] new_pc;
  logic        pc_load;
  logic [3:0]  depth;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        underflow;

  int tests = 0;
  int fails = 0;

  // Reference state: the stack is a plain queue of return addresses.
  logic [19:0] q[$];
  logic [19:0] m_new_pc;
  logic        m_pc_load;
  logic        m_ovf;
  logic        m_unf;

  call_ret_stack #(.ADDR_W(20), .DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .call_address(call_address),
    .call_req(call_req), .ret_req(ret_req), .sign_flag(sign_flag),
    .flag_clr(flag_clr), .new_pc(new_pc), .pc_load(pc_load), .depth(depth),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic acc;
    logic set_o;
    logic set_u;
    set_o = 1'b0;
    set_u = 1'b0;
`ifdef CALL_RET_COND_EN
    acc = sign_flag;
`else
    acc = 1'b1;
`endif
    if (!rst_n) begin
      q.delete();
      m_new_pc  = '0;
      m_pc_load = 1'b0;
      m_ovf     = 1'b0;
      m_unf     = 1'b0;
    end else begin
      m_pc_load = 1'b0;
      if (call_req && acc) begin
        if (q.size() == 8) set_o = 1'b1;
        else begin
          q.push_back(pc + 20'd1);
          m_new_pc  = call_address;
          m_pc_load = 1'b1;
        end
      end else if (ret_req && !call_req && acc) begin
        if (q.size() == 0) set_u = 1'b1;
        else begin
          m_new_pc  = q.pop_back();
          m_pc_load = 1'b1;
        end
      end
      m_ovf = set_o ? 1'b1 : (flag_clr ? 1'b0 : m_ovf);
      m_unf = set_u ? 1'b1 : (flag_clr ? 1'b0 : m_unf);
    end
  endtask

  task automatic step(input logic rn, input logic c, input logic r, input logic s,
                      input logic fc, input logic [19:0] p, input logic [19:0] ca);
    @(negedge clk);
    rst_n = rn; call_req = c; ret_req = r; sign_flag = s; flag_clr = fc;
    pc = p; call_address = ca;
    @(posedge clk);
    model_update();
    #1;
    chk("new_pc", new_pc, m_new_pc);
    chk("pc_load", pc_load, m_pc_load);
    chk("depth", depth, q.size());
    chk("full", full, q.size() == 8);
    chk("empty", empty, q.size() == 0);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
  endtask

  initial begin
    rst_n = 1'b0; call_req = 1'b0; ret_req = 1'b0; sign_flag = 1'b1;
    flag_clr = 1'b0; pc = '0; call_address = '0;
    m_new_pc = '0; m_pc_load = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset state
    step(0, 0, 0, 1, 0, 20'h0, 20'h0);
    chk("reset_empty", empty, 1'b1);

    // Basic linkage
    step(1, 1, 0, 1, 0, 20'h00100, 20'hABCDE);
    chk("basic_call_target", new_pc, 20'hABCDE);
    chk("basic_call_depth", depth, 4'd1);
    step(1, 0, 1, 1, 0, 20'hABCDE, 20'h0);
    chk("basic_ret_target", new_pc, 20'h00101);
    step(1, 0, 0, 1, 0, 20'h00101, 20'h0);
    chk("load_one_cycle", pc_load, 1'b0);

    // Nesting: LIFO order
    step(1, 1, 0, 1, 0, 20'h00010, 20'h01000);
    step(1, 1, 0, 1, 0, 20'h00020, 20'h02000);
    step(1, 1, 0, 1, 0, 20'h00030, 20'h03000);
    step(1, 0, 1, 1, 0, 20'h0, 20'h0);
    chk("lifo_1", new_pc, 20'h00031);
    step(1, 0, 1, 1, 0, 20'h0, 20'h0);
    chk("lifo_2", new_pc, 20'h00021);
    step(1, 0, 1, 1, 0, 20'h0, 20'h0);
    chk("lifo_3", new_pc, 20'h00011);

    // Full / overflow
    for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 0, 20'h00200 + 20'(i), 20'h05000 + 20'(i));
    step(1, 1, 0, 1, 0, 20'h00300, 20'h06000);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_depth", depth, 4'd8);
    chk("ovf_no_load", pc_load, 1'b0);
    step(1, 0, 1, 1, 0, 20'h0, 20'h0);
    chk("ovf_ret_8th", new_pc, 20'h00208);
    step(1, 0, 0, 1, 1, 20'h0, 20'h0);
    chk("ovf_cleared", overflow, 1'b0);

    // Empty / underflow and address wrap
    step(0, 0, 0, 1, 0, 20'h0, 20'h0);
    step(1, 0, 1, 1, 0, 20'h0, 20'h0);
    chk("unf_flag", underflow, 1'b1);
    step(1, 1, 0, 1, 1, 20'hFFFFF, 20'h12345);
    step(1, 0, 1, 1, 0, 20'h12345, 20'h0);
    chk("wrap_ret", new_pc, 20'h00000);

    // Simultaneous requests, then reset against a request
    step(1, 1, 1, 1, 0, 20'h00400, 20'h0BEEF);
    chk("simul_target", new_pc, 20'h0BEEF);
    step(0, 1, 0, 1, 0, 20'h00500, 20'h0CAFE);
    chk("rst_prio_depth", depth, 4'd0);

`ifdef CALL_RET_COND_EN
    step(1, 1, 0, 0, 0, 20'h00100, 20'hABCDE);
    chk("cond_reject", pc_load, 1'b0);
    step(1, 1, 0, 1, 0, 20'h00100, 20'hABCDE);
    chk("cond_accept", new_pc, 20'hABCDE);
`endif

    // Random traffic, biased so the stack reaches both ends
    for (int i = 0; i < 600; i++) begin
      logic [19:0] rp;
      rp = ($urandom_range(0, 15) == 0) ? 20'hFFFFF : 20'($urandom);
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 99) < ((i / 100) % 2 ? 30 : 55),
           $urandom_range(0, 99) < 45,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0,
           rp, 20'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
